// File: rtl/sha_block_word_reader_pkg.sv
// Shared constants, occupancy encoding and word helpers for the SHA-2
// block word reader.
package sha_blk_pkg;

   localparam int WORD_W        = 32;
   localparam int WORDS_PER_BLK = 4;
   localparam int BLOCK_W       = WORD_W * WORDS_PER_BLK;
   localparam int WIDX_W        = $clog2(WORDS_PER_BLK);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_HALF  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   // Word i of a block in big-endian SHA order: word 0 is the top WORD_W bits.
   function automatic logic [WORD_W-1:0] blk_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [WIDX_W-1:0]  i);
      return blk[BLOCK_W-1-int'(i)*WORD_W -: WORD_W];
   endfunction

   // Byte-reverse one word, for little-endian producers.
   function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int b = 0; b < WORD_W/8; b++) begin
         r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha_block_word_reader_if.sv
// Block-in / word-out handshake bundle of the SHA-2 block word reader.
// slave: the reader itself; master: the producer/consumer environment.
interface sha_block_word_reader_if;

   logic                                blk_valid;
   logic                                blk_ready;
   logic [sha_blk_pkg::BLOCK_W-1:0]     blk_data;
   logic                                blk_last;
   logic                                word_valid;
   logic                                word_ready;
   logic [sha_blk_pkg::WORD_W-1:0]      word_data;
   logic [sha_blk_pkg::WIDX_W-1:0]      word_idx;
   logic                                word_last;

   modport slave (
      input  blk_valid, blk_data, blk_last, word_ready,
      output blk_ready, word_valid, word_data, word_idx, word_last
   );

   modport master (
      output blk_valid, blk_data, blk_last, word_ready,
      input  blk_ready, word_valid, word_data, word_idx, word_last
   );

endinterface

// File: rtl/sha_block_word_reader_slot.sv
// One ping-pong slot: block payload plus last flag, loaded only when
// written and cleared by reset.
import sha_blk_pkg::*;

module sha_blk_slot #(
   parameter int W = BLOCK_W + 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture on write enable; asynchronous clear so outputs read 0 in reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) q <= '0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/sha_block_word_reader.sv
// SHA-2 block word reader: two-slot ping-pong buffer of 128-bit blocks,
// streamed out as 32-bit words, most significant word first.
// Optional build macro: SHA_BLK_BSWAP_EN byte-reverses every output word.
import sha_blk_pkg::*;

module sha_block_word_reader (
   input  logic                   CLK,
   input  logic                   RST,
   sha_block_word_reader_if.slave bus
);

   localparam logic [WIDX_W-1:0] WC_LAST = WIDX_W'(WORDS_PER_BLK - 1);

   occ_t              occ_q, occ_d;
   logic              wp_q, rp_q;
   logic [WIDX_W-1:0] wc_q;
   logic              accept, rel, word_hs;
   logic [BLOCK_W:0]  slot0_q, slot1_q, cur;
   logic [WORD_W-1:0] word_raw;

   assign accept  = bus.blk_valid && bus.blk_ready;
   assign word_hs = bus.word_valid && bus.word_ready;
   assign rel     = word_hs && (wc_q == WC_LAST);

   // Ping-pong storage; the write pointer picks which slot an accepted block lands in.
   sha_blk_slot #(.W(BLOCK_W + 1)) u_slot0 (
      .CLK (CLK), .RST (RST), .we (accept && !wp_q),
      .d   ({bus.blk_last, bus.blk_data}), .q (slot0_q)
   );

   sha_blk_slot #(.W(BLOCK_W + 1)) u_slot1 (
      .CLK (CLK), .RST (RST), .we (accept && wp_q),
      .d   ({bus.blk_last, bus.blk_data}), .q (slot1_q)
   );

   // Occupancy state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) occ_q <= OCC_EMPTY;
      else     occ_q <= occ_d;
   end

   // Occupancy next state: accept fills, release drains, both together hold.
   always_comb begin
      occ_d = occ_q;
      case (occ_q)
         OCC_EMPTY: if (accept) occ_d = OCC_HALF;
         OCC_HALF:  begin
            if (accept && !rel)      occ_d = OCC_FULL;
            else if (rel && !accept) occ_d = OCC_EMPTY;
         end
         OCC_FULL:  if (rel) occ_d = OCC_HALF;
         default:   occ_d = OCC_EMPTY;
      endcase
   end

   // Pointers toggle per accept/release; word counter steps per word handshake.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wp_q <= 1'b0;
         rp_q <= 1'b0;
         wc_q <= '0;
      end else begin
         if (accept) wp_q <= ~wp_q;
         if (rel) begin
            rp_q <= ~rp_q;
            wc_q <= '0;
         end else if (word_hs) begin
            wc_q <= wc_q + WIDX_W'(1);
         end
      end
   end

   // Output mux: current read slot, current word.
   always_comb begin
      cur      = rp_q ? slot1_q : slot0_q;
      word_raw = blk_word(cur[BLOCK_W-1:0], wc_q);
   end

   // Ready is withheld during reset so nothing is offered into a clearing buffer.
   assign bus.blk_ready  = (occ_q != OCC_FULL) && !RST;
   assign bus.word_valid = (occ_q != OCC_EMPTY);
   assign bus.word_idx   = wc_q;
   assign bus.word_last  = cur[BLOCK_W] && (wc_q == WC_LAST);
`ifdef SHA_BLK_BSWAP_EN
   assign bus.word_data  = byte_swap(word_raw);
`else
   assign bus.word_data  = word_raw;
`endif

endmodule

// File: tb/tb_sha_block_word_reader.sv
// Scoreboard bench for sha_block_word_reader: accepted blocks push their
// expected words; a negedge monitor pops and compares on every word handshake.
import sha_blk_pkg::*;

module tb_sha_block_word_reader;

   typedef struct packed {
      logic [WORD_W-1:0] d;
      logic [WIDX_W-1:0] i;
      logic              l;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   sha_block_word_reader_if bus();

   sha_block_word_reader dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [WORD_W-1:0] act,
                        input logic [WORD_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] exp_word(input logic [BLOCK_W-1:0] b, input int i);
      logic [WORD_W-1:0] w;
      w = b[BLOCK_W-1-i*WORD_W -: WORD_W];
`ifdef SHA_BLK_BSWAP_EN
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      return w;
   endfunction

   // Offer a block, wait (bounded) for acceptance, then push its words.
   task automatic send_block(input logic [BLOCK_W-1:0] b, input logic last);
      int n;
      exp_t e;
      bus.blk_valid = 1'b1;
      bus.blk_data  = b;
      bus.blk_last  = last;
      n = 0;
      forever begin
         @(negedge CLK);
         if (bus.blk_ready) break;
         n++;
         if (n > 50) begin
            check("blk_accept_timeout", 32'd0, 32'd1);
            bus.blk_valid = 1'b0;
            return;
         end
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
         e.d = exp_word(b, i);
         e.i = WIDX_W'(i);
         e.l = last && (i == WORDS_PER_BLK - 1);
         sb.push_back(e);
      end
   endtask

   // Monitor: every word handshake must match the head of the scoreboard.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST && bus.word_valid && bus.word_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", bus.word_data, 32'hxxxxxxxx);
         end else begin
            e = sb.pop_front();
            check("word_data", bus.word_data, e.d);
            check("word_idx", 32'(bus.word_idx), 32'(e.i));
            check("word_last", 32'(bus.word_last), 32'(e.l));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   localparam logic [BLOCK_W-1:0] BLK_T = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [BLOCK_W-1:0] BLK_A = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
   localparam logic [BLOCK_W-1:0] BLK_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
   localparam logic [BLOCK_W-1:0] BLK_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
   localparam logic [BLOCK_W-1:0] BLK_D = 128'hD0000001_D0000002_D0000003_D0000004;
   localparam logic [BLOCK_W-1:0] BLK_E = 128'hE0000001_E0000002_E0000003_E0000004;
   localparam logic [BLOCK_W-1:0] BLK_K = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   initial begin
      logic [WORD_W-1:0] w0;
      int n;
      bus.blk_valid  = 1'b0;
      bus.blk_data   = '0;
      bus.blk_last   = 1'b0;
      bus.word_ready = 1'b1;

      // Reset state
      @(negedge CLK);
      check("rst_word_valid", 32'(bus.word_valid), 32'd0);
      check("rst_word_data", bus.word_data, 32'd0);
      check("rst_blk_ready", 32'(bus.blk_ready), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_blk_ready", 32'(bus.blk_ready), 32'd1);

      // Single block, latency and word_last position; word 0 checked by hand too
`ifdef SHA_BLK_BSWAP_EN
      w0 = 32'h33221100;
`else
      w0 = 32'h00112233;
`endif
      @(posedge CLK); #1;
      send_block(BLK_T, 1'b1);
      bus.blk_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("single_valid", 32'(bus.word_valid), 32'd1);
         check("single_idx", 32'(bus.word_idx), 32'(k));
         if (k == 0) check("single_word0", bus.word_data, w0);
      end
      @(negedge CLK);
      check("single_done_valid", 32'(bus.word_valid), 32'd0);

      // Back-to-back: three blocks, 12 words without a gap
      @(posedge CLK); #1;
      fork
         begin
            send_block(BLK_A, 1'b0);
            send_block(BLK_B, 1'b0);
            send_block(BLK_C, 1'b1);
            bus.blk_valid = 1'b0;
         end
         begin
            n = 0;
            do begin
               @(negedge CLK);
               n++;
            end while (!bus.word_valid && n < 20);
            for (int k = 0; k < 12; k++) begin
               if (k > 0) @(negedge CLK);
               check("b2b_valid", 32'(bus.word_valid), 32'd1);
               if (k == 3) check("b2b_full_ready", 32'(bus.blk_ready), 32'd0);
               if (k == 4) check("b2b_ready_back", 32'(bus.blk_ready), 32'd1);
            end
            @(negedge CLK);
            check("b2b_done_valid", 32'(bus.word_valid), 32'd0);
         end
      join

      // Backpressure: stall 5 cycles at word_idx 2
      @(posedge CLK); #1;
      send_block(BLK_K, 1'b1);
      bus.blk_valid = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      bus.word_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("stall_valid", 32'(bus.word_valid), 32'd1);
         check("stall_idx", 32'(bus.word_idx), 32'd2);
         check("stall_data", bus.word_data, exp_word(BLK_K, 2));
      end
      @(posedge CLK); #1;
      bus.word_ready = 1'b1;
      repeat (4) @(posedge CLK);
      #1;

      // Simultaneous accept and release while HALF
      send_block(BLK_D, 1'b0);
      bus.blk_valid = 1'b0;
      repeat (3) begin
         @(posedge CLK); #1;
      end
      send_block(BLK_E, 1'b1);
      bus.blk_valid = 1'b0;
      @(negedge CLK);
      check("sim_valid", 32'(bus.word_valid), 32'd1);
      check("sim_idx", 32'(bus.word_idx), 32'd0);
      check("sim_half_ready", 32'(bus.blk_ready), 32'd1);
      repeat (5) @(posedge CLK);
      #1;

      // Reset mid-operation with FULL buffer at word_idx 1
      send_block(BLK_A, 1'b0);
      send_block(BLK_B, 1'b1);
      bus.blk_valid = 1'b0;
      @(negedge CLK);
      check("pre_rst_idx", 32'(bus.word_idx), 32'd1);
      check("pre_rst_ready", 32'(bus.blk_ready), 32'd0);
      #1;
      RST = 1'b1;
      sb.delete();
      @(negedge CLK);
      check("mid_rst_valid", 32'(bus.word_valid), 32'd0);
      check("mid_rst_data", bus.word_data, 32'd0);
      check("mid_rst_idx", 32'(bus.word_idx), 32'd0);
      check("mid_rst_last", 32'(bus.word_last), 32'd0);
      check("mid_rst_ready", 32'(bus.blk_ready), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("after_rst_ready", 32'(bus.blk_ready), 32'd1);
      check("after_rst_valid", 32'(bus.word_valid), 32'd0);
      @(posedge CLK); #1;
      send_block(BLK_C, 1'b1);
      bus.blk_valid = 1'b0;

      // Drain scoreboard (bounded)
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge CLK);
         n++;
      end
      @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sha_block_word_reader.md
# sha_block_word_reader

Read-side counterpart of the 128-bit block store in the SHA-2 datapath. Accepts 128-bit message blocks over a valid/ready handshake, holds up to two in a ping-pong buffer, and streams each block as four 32-bit words, most significant word first, to the message expander. A block can be loaded while the previous one is still streaming, so words can be emitted back-to-back at one word per cycle.

## Interface
Parameters:
- WORD_W, 32: output word width.
- BLOCK_W, 128: block width; must equal WORD_W × WORDS_PER_BLK.
- WORDS_PER_BLK, 4: words per block; word index width = clog2(WORDS_PER_BLK).

Ports (CLK, single clock; RST, asynchronous, active-high):
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- blk_valid  in  1  producer offers a block.
- blk_ready  out  1  a buffer slot is free.
- blk_data  in  BLOCK_W  block payload.
- blk_last  in  1  block is the final block of the message.
- word_valid  out  1  word_data is valid.
- word_ready  in  1  consumer takes the word.
- word_data  out  WORD_W  current word.
- word_idx  out  clog2(WORDS_PER_BLK)  index of word_data within its block.
- word_last  out  1  last word of a block tagged blk_last.

## Operation
- Storage: two slots (data + last flag), write pointer wp, read pointer rp, occupancy occ ∈ {0,1,2}, word counter wc.
- Occupancy FSM: EMPTY (occ=0), HALF (occ=1), FULL (occ=2).
  - Accept = blk_valid && blk_ready. Release = word_valid && word_ready && wc==WORDS_PER_BLK-1.
  - Accept only: occ+1, wp toggles. Release only: occ-1, rp toggles, wc→0. Both: occ unchanged, both pointers toggle.
- blk_ready = (occ != 2). It is combinational from state only and never depends on blk_valid or word_ready. Release and accept in the same cycle while FULL is therefore not possible, because blk_ready is 0.
- word_valid = (occ != 0).
- word_data = slot[rp] word wc, with word 0 = bits [BLOCK_W-1 -: WORD_W] (big-endian SHA order).
- word_idx = wc.
- word_last = slot[rp].last && wc==WORDS_PER_BLK-1.
- wc increments on each word handshake and wraps WORDS_PER_BLK-1→0 on release.
- Stall rule: while word_valid && !word_ready, word_data, word_idx and word_last hold stable.
- blk_data is ignored unless accepted. A blk_valid-held block is not required to stay stable while blk_ready=0.

## Timing
- Reset (RST high, any time, including mid-block): occ=0, wp=rp=0, wc=0.
  - While RST is high: word_valid=0, word_data=0, word_idx=0, word_last=0, blk_ready=0.
  - After RST falls: blk_ready=1 in the first cycle.
  - Any partially streamed block is discarded.
- Latency: block accepted at edge N → word 0 valid after edge N, i.e. in cycle N+1; last word in cycle N+4 with word_ready held high.
- Throughput: with a continuous producer and word_ready=1, word_valid stays high with no bubbles between blocks.
- Slot storage is written only on accept and never on release.

## Configuration
- SHA_BLK_BSWAP_EN defined: each WORD_W word is byte-reversed on output, for little-endian producers. word order within the block is unchanged.
- SHA_BLK_BSWAP_EN undefined: words are output unchanged.

## Structure
- Package sha_blk_pkg holds:
  - constants WORD_W, BLOCK_W, WORDS_PER_BLK, WIDX_W;
  - occupancy encoding typedef (OCC_EMPTY, OCC_HALF, OCC_FULL);
  - word-select function returning word i, big-endian.
- Sub-module sha_blk_slot: BLOCK_W+1-bit register with write enable and async active-high clear. It is instantiated twice for the ping-pong buffer.
- The top level holds the FSM, pointers, counter, output mux and optional byte swap.

## Test plan
- Reset then single block: blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, blk_last=1, word_ready=1.
  - Words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF in cycles N+1..N+4; word_idx 0..3.
  - word_last=1 only on 0xCCDDEEFF; word_valid=0 after.
- Back-to-back: three blocks offered continuously with word_ready=1 → 12 consecutive valid words with no gap.
  - blk_ready drops to 0 when both slots are held, and returns to 1 in the cycle after the first block's last word.
- Backpressure: word_ready=0 for 5 cycles at word_idx=2 → word_data/idx stable throughout; no word lost or repeated.
- Simultaneous accept and release in HALF state → occ stays 1, next block's word 0 appears immediately after the previous word 3.
- Reset mid-operation: assert RST at word_idx=1 with FULL buffer.
  - All outputs 0 and blk_ready=0 during reset.
  - After release, a new block streams from word 0.
- With SHA_BLK_BSWAP_EN defined: word 0 of the first test block reads 0x33221100.
